// File: rtl/morse_pkg.sv
// Shared Morse link definitions: symbol codes, default letter gap and the
// A..H letter table (symbol count and code per letter index).
package morse_pkg;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int LETTER_GAP_DEF = 3;
  localparam int N_LETTERS      = 8;

  // Entries listed from index 7 (H) down to index 0 (A); codes are right-aligned.
  localparam logic [7:0][2:0] LETTER_LEN = {
    3'd4, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd4, 3'd2
  };
  localparam logic [7:0][3:0] LETTER_SYM = {
    4'b0000, 4'b0110, 4'b0010, 4'b0000, 4'b0100, 4'b1010, 4'b1000, 4'b0001
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/morse_symbol_lookup.sv
// Combinational match of a collected symbol string (len, sym) against the
// letter table; returns hit and the matching letter index.
module morse_symbol_lookup
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [3:0] sym,
  output logic       hit,
  output logic [2:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = 3'd0;
    for (int i = 0; i < N_LETTERS; i++) begin
      if (len == LETTER_LEN[i] && sym == LETTER_SYM[i]) begin
        hit   = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: classifies high runs into dots/dashes, collects up to four
// symbols per letter and reports the letter index (Valid) or Err after a gap.
//
// state | meaning
// IDLE  | line low, no letter in progress
// MARK  | counting a high run (current symbol)
// SPACE | counting a low run; short = symbol gap, LETTER_GAP = end of letter
// EMIT  | one-cycle result slot, Valid/Err pulse visible, letter state cleared
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DOT_MAX    = 2,
  parameter int DASH_MIN   = 3,
  parameter int DASH_MAX   = 5,
  parameter int LETTER_GAP = LETTER_GAP_DEF,
  parameter int CNT_W      = 4
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       I,
  output logic [2:0] O,
  output logic       Valid,
  output logic       Err
);

  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DOT_HI   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_LO  = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] DASH_HI  = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] run_inc;
  logic [3:0]       sym_q, sym_d;
  logic [2:0]       len_q, len_d;
  logic             bad_q, bad_d;
  logic [2:0]       o_d;
  logic             valid_d, err_d;

  logic             is_dot, is_dash;
  logic             lut_hit;
  logic [2:0]       lut_index;

  morse_symbol_lookup u_lookup (
    .len   (len_q),
    .sym   (sym_q),
    .hit   (lut_hit),
    .index (lut_index)
  );

  assign run_inc = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;
  assign is_dot  = (run_q != '0) && (run_q <= DOT_HI);
  assign is_dash = (run_q >= DASH_LO) && (run_q <= DASH_HI);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    sym_d   = sym_q;
    len_d   = len_q;
    bad_d   = bad_q;
    o_d     = O;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end
      end

      ST_MARK: begin
        if (I) begin
          run_d = run_inc;
        end else begin
          // A fifth symbol flags the letter but leaves the collected code as is.
          if (len_q == 3'd4) begin
            bad_d = 1'b1;
          end else begin
            sym_d = {sym_q[2:0], is_dash ? SYM_DASH : SYM_DOT};
            len_d = len_q + 3'd1;
          end
          if (!is_dot && !is_dash) bad_d = 1'b1;
          state_d = ST_SPACE;
          run_d   = RUN_ONE;
        end
      end

      ST_SPACE: begin
        if (I) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end else if (run_q >= GAP_LAST) begin
          // Outputs are registered here so the pulse lines up with EMIT.
          state_d = ST_EMIT;
          run_d   = run_inc;
          if (!bad_q && lut_hit) begin
            o_d     = lut_index;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          run_d = run_inc;
        end
      end

      ST_EMIT: begin
        sym_d = 4'b0;
        len_d = 3'd0;
        bad_d = 1'b0;
        if (I) begin
          state_d = ST_MARK;
          run_d   = RUN_ONE;
        end else begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      sym_q   <= 4'b0;
      len_q   <= 3'd0;
      bad_q   <= 1'b0;
      O       <= 3'd0;
      Valid   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      bad_q   <= bad_d;
      O       <= o_d;
      Valid   <= valid_d;
      Err     <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: table of letters sent as high/low runs, expected
// results queued at send time and matched by a monitor on Valid/Err pulses.
module tb_morse_decoder;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic       I   = 1'b0;
  logic [2:0] O;
  logic       Valid, Err;

  int compared   = 0;
  int mismatched = 0;
  int pcyc       = 0;

  typedef struct {
    string      code;
    int         dot_len;
    int         dash_len;
    bit         exp_valid;
    logic [2:0] exp_o;
  } vec_t;

  typedef struct {
    bit         exp_valid;
    logic [2:0] exp_o;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] last_o = 3'd0;

  morse_decoder dut (
    .Clk   (Clk),
    .Clr   (Clr),
    .I     (I),
    .O     (O),
    .Valid (Valid),
    .Err   (Err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) pcyc++;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, pcyc);
    end
  endtask

  task automatic tick(input logic v);
    @(negedge Clk);
    I = v;
  endtask

  // Symbols separated by one low, then exactly three lows; the third low
  // is sampled at the next posedge and the pulse is seen on the negedge after.
  task automatic send_letter(input vec_t v);
    exp_t e;
    for (int i = 0; i < v.code.len(); i++) begin
      repeat ((v.code[i] == "-") ? v.dash_len : v.dot_len) tick(1'b1);
      if (i < v.code.len() - 1) tick(1'b0);
    end
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    e.exp_valid = v.exp_valid;
    e.exp_o     = v.exp_o;
    e.due       = pcyc + 1;
    sb.push_back(e);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Valid === 1'b1 && Err === 1'b1)
      chk("valid_err_exclusive", 1, 0);
    if (Valid === 1'b1 || Err === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, Valid, Err, 1'b0}, 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_valid", int'(Valid), int'(e.exp_valid));
        chk("pulse_cycle", pcyc, e.due);
        if (e.exp_valid) begin
          chk("letter_o", int'(O), int'(e.exp_o));
          last_o = e.exp_o;
        end else begin
          chk("o_held_on_err", int'(O), int'(last_o));
        end
      end
    end
    if (sb.size() > 0 && pcyc > sb[0].due) begin
      chk("missing_pulse", 0, 1);
      void'(sb.pop_front());
    end
  end

  vec_t vecs[$];

  initial begin
    vecs.push_back('{".-",    1, 3, 1'b1, 3'd0});
    vecs.push_back('{"-...",  1, 3, 1'b1, 3'd1});
    vecs.push_back('{"-.-.",  1, 3, 1'b1, 3'd2});
    vecs.push_back('{"-..",   1, 3, 1'b1, 3'd3});
    vecs.push_back('{".",     1, 3, 1'b1, 3'd4});
    vecs.push_back('{"..-.",  1, 3, 1'b1, 3'd5});
    vecs.push_back('{"--.",   1, 3, 1'b1, 3'd6});
    vecs.push_back('{"....",  1, 3, 1'b1, 3'd7});
    vecs.push_back('{".-",    2, 5, 1'b1, 3'd0});
    vecs.push_back('{".-",    1, 6, 1'b0, 3'd0});
    vecs.push_back('{".....", 1, 3, 1'b0, 3'd0});
    vecs.push_back('{"----",  1, 3, 1'b0, 3'd0});
    vecs.push_back('{"..-.",  2, 4, 1'b1, 3'd5});
    vecs.push_back('{"-",     1, 3, 1'b0, 3'd0});

    // Reset with the line held high
    Clr = 1'b1;
    I   = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("reset_o", int'(O), 0);
    chk("reset_valid", int'(Valid), 0);
    chk("reset_err", int'(Err), 0);
    Clr = 1'b0;
    I   = 1'b0;
    repeat (10) tick(1'b0);

    // Letter A with exact pulse timing, then the table back to back
    foreach (vecs[k]) send_letter(vecs[k]);
    repeat (6) tick(1'b0);

    // Clear arriving with the letter-ending low wins over the emit
    repeat (1) tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    @(negedge Clk);
    I   = 1'b0;
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    chk("clr_priority_o", int'(O), 0);
    last_o = 3'd0;
    repeat (6) tick(1'b0);

    // Clear after a partial "-." then E
    repeat (3) tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    @(negedge Clk);
    I   = 1'b0;
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    send_letter('{".", 1, 3, 1'b1, 3'd4});

    repeat (10) tick(1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
